// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer: merges stage stall requests and sequences exception/ERET redirects.
// Optional perf counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_stall_ctrl #(
    parameter int unsigned FLUSH_HOLD = 1,
    parameter logic [31:0] EXC_VEC    = 32'hBFC00380
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int unsigned PERF_W     = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              exc_valid,
    input  logic              exc_eret,
    input  logic [31:0]       cp0_epc,
    output logic [3:0]        stall,
    output logic              flush,
    output logic              flush_cause,
    output logic [31:0]       new_pc
`ifdef PIPE_PERF_CNT_EN
    ,
    input  logic              perf_clr,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

    localparam int unsigned HOLD_W = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [3:0]        stall_raw;
    logic              exc_any;

    assign exc_any = exc_valid | exc_eret;

    // State register plus registered redirect outputs, loaded on the edge entering FLUSH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            hold_cnt    <= '0;
            flush       <= 1'b0;
            flush_cause <= 1'b0;
            new_pc      <= '0;
        end else begin
            state <= state_nxt;
            flush <= (state_nxt == FLUSH);
            if (state_nxt == FLUSH) begin
                flush_cause <= exc_valid;
                new_pc      <= exc_valid ? EXC_VEC : cp0_epc;
            end
            if (state == FLUSH) begin
                hold_cnt <= HOLD_W'(FLUSH_HOLD);
            end else if (state == HOLD) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
        end
    end

    // Next state and stall vector; the faulting instruction stays blocked from WB until the flush.
    always_comb begin
        state_nxt = state;
        stall_raw = 4'b0000;
        case (state)
            RUN: begin
                if (exc_any) begin
                    stall_raw = 4'b0111;
                    state_nxt = stallreq_mem ? DRAIN : FLUSH;
                end else if (stallreq_mem) begin
                    stall_raw = 4'b0111;
                end else if (stallreq_ex) begin
                    stall_raw = 4'b0011;
                end else if (stallreq_id) begin
                    stall_raw = 4'b0001;
                end
            end
            DRAIN: begin
                stall_raw = 4'b0111;
                if (!stallreq_mem) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                stall_raw = 4'b0001;
                if (hold_cnt <= HOLD_W'(1)) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Stall drops immediately while reset is asserted, independent of the request inputs.
    assign stall = rst ? stall_raw : 4'b0000;

`ifdef PIPE_PERF_CNT_EN
    // Saturating event counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else if (perf_clr) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if ((stall != 4'b0000) && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
            end
            if (flush && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + PERF_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: stall merging, exception/ERET flush sequencing, async reset.
module tb_pipe_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        exc_valid;
    logic        exc_eret;
    logic [31:0] cp0_epc;
    logic [3:0]  stall;
    logic        flush;
    logic        flush_cause;
    logic [31:0] new_pc;
`ifdef PIPE_PERF_CNT_EN
    logic        perf_clr;
    logic [3:0]  perf_stall_cnt;
    logic [3:0]  perf_flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] EXC_VEC = 32'hBFC00380;

`ifdef PIPE_PERF_CNT_EN
    pipe_stall_ctrl #(.FLUSH_HOLD(1), .EXC_VEC(EXC_VEC), .PERF_W(4)) dut (
`else
    pipe_stall_ctrl #(.FLUSH_HOLD(1), .EXC_VEC(EXC_VEC)) dut (
`endif
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .exc_valid    (exc_valid),
        .exc_eret     (exc_eret),
        .cp0_epc      (cp0_epc),
        .stall        (stall),
        .flush        (flush),
        .flush_cause  (flush_cause),
        .new_pc       (new_pc)
`ifdef PIPE_PERF_CNT_EN
        ,
        .perf_clr       (perf_clr),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        exc_valid = 0; exc_eret = 0; cp0_epc = '0;
`ifdef PIPE_PERF_CNT_EN
        perf_clr = 0;
`endif
        #2;
        checks++; if (stall !== 4'b0000) begin errors++; $display("FAIL reset_stall got=%b exp=0000", stall); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", flush); end
        checks++; if (new_pc !== 32'h0) begin errors++; $display("FAIL reset_new_pc got=%h exp=0", new_pc); end
        checks++; if (flush_cause !== 1'b0) begin errors++; $display("FAIL reset_cause got=%b exp=0", flush_cause); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_id_stall();
        stallreq_id = 1; #1;
        checks++; if (stall !== 4'b0001) begin errors++; $display("FAIL id_c0 got=%b exp=0001", stall); end
        tick();
        checks++; if (stall !== 4'b0001) begin errors++; $display("FAIL id_c1 got=%b exp=0001", stall); end
        tick();
        stallreq_id = 0; #1;
        checks++; if (stall !== 4'b0000) begin errors++; $display("FAIL id_release got=%b exp=0000", stall); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL id_flush got=%b exp=0", flush); end
        tick();
    endtask

    task automatic test_ex_stall();
        stallreq_ex = 1; stallreq_id = 1; #1;
        checks++; if (stall !== 4'b0011) begin errors++; $display("FAIL ex_id got=%b exp=0011", stall); end
        tick();
        stallreq_ex = 0; #1;
        checks++; if (stall !== 4'b0001) begin errors++; $display("FAIL ex_drop got=%b exp=0001", stall); end
        tick();
        stallreq_mem = 1; stallreq_ex = 1; #1;
        checks++; if (stall !== 4'b0111) begin errors++; $display("FAIL mem_prio got=%b exp=0111", stall); end
        tick();
        stallreq_mem = 0; stallreq_ex = 0; stallreq_id = 0;
    endtask

    task automatic test_exception();
        exc_valid = 1; #1;
        checks++; if (stall !== 4'b0111) begin errors++; $display("FAIL exc_n_stall got=%b exp=0111", stall); end
        tick();
        exc_valid = 0; stallreq_id = 1; #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL exc_n1_flush got=%b exp=1", flush); end
        checks++; if (flush_cause !== 1'b1) begin errors++; $display("FAIL exc_n1_cause got=%b exp=1", flush_cause); end
        checks++; if (new_pc !== EXC_VEC) begin errors++; $display("FAIL exc_n1_pc got=%h exp=%h", new_pc, EXC_VEC); end
        checks++; if (stall !== 4'b0000) begin errors++; $display("FAIL exc_n1_stall got=%b exp=0000", stall); end
        tick();
        stallreq_id = 0; #1;
        checks++; if (stall !== 4'b0001) begin errors++; $display("FAIL exc_n2_stall got=%b exp=0001", stall); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL exc_n2_flush got=%b exp=0", flush); end
        tick();
        checks++; if (stall !== 4'b0000) begin errors++; $display("FAIL exc_n3_stall got=%b exp=0000", stall); end
        checks++; if (new_pc !== EXC_VEC) begin errors++; $display("FAIL exc_pc_hold got=%h exp=%h", new_pc, EXC_VEC); end
    endtask

    task automatic test_eret_drain();
        exc_eret = 1; cp0_epc = 32'h8000_1234; stallreq_mem = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (stall !== 4'b0111) begin errors++; $display("FAIL drain_stall c%0d got=%b exp=0111", i, stall); end
            checks++; if (flush !== 1'b0) begin errors++; $display("FAIL drain_flush c%0d got=%b exp=0", i, flush); end
            tick();
        end
        stallreq_mem = 0;
        tick();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL eret_flush got=%b exp=1", flush); end
        checks++; if (flush_cause !== 1'b0) begin errors++; $display("FAIL eret_cause got=%b exp=0", flush_cause); end
        checks++; if (new_pc !== 32'h8000_1234) begin errors++; $display("FAIL eret_pc got=%h exp=80001234", new_pc); end
        exc_eret = 0;
        tick();
        tick();
    endtask

    task automatic test_exc_and_eret();
        exc_valid = 1; exc_eret = 1; cp0_epc = 32'h1234_5678;
        tick();
        exc_valid = 0; exc_eret = 0;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL both_flush got=%b exp=1", flush); end
        checks++; if (flush_cause !== 1'b1) begin errors++; $display("FAIL both_cause got=%b exp=1", flush_cause); end
        checks++; if (new_pc !== EXC_VEC) begin errors++; $display("FAIL both_pc got=%h exp=%h", new_pc, EXC_VEC); end
        tick();
        tick();
    endtask

    task automatic test_reset_in_drain();
        exc_valid = 1; stallreq_mem = 1;
        tick();
        checks++; if (stall !== 4'b0111) begin errors++; $display("FAIL rdrain_pre got=%b exp=0111", stall); end
        #2 rst = 1'b0;
        #1;
        checks++; if (stall !== 4'b0000) begin errors++; $display("FAIL rdrain_stall got=%b exp=0000", stall); end
        checks++; if (new_pc !== 32'h0) begin errors++; $display("FAIL rdrain_pc got=%h exp=0", new_pc); end
        checks++; if (flush_cause !== 1'b0) begin errors++; $display("FAIL rdrain_cause got=%b exp=0", flush_cause); end
        exc_valid = 0; stallreq_mem = 0;
        #1 rst = 1'b1;
        tick();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rdrain_noflush0 got=%b exp=0", flush); end
        tick();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rdrain_noflush1 got=%b exp=0", flush); end
        stallreq_id = 1; #1;
        checks++; if (stall !== 4'b0001) begin errors++; $display("FAIL rdrain_run got=%b exp=0001", stall); end
        tick();
        stallreq_id = 0;
    endtask

`ifdef PIPE_PERF_CNT_EN
    task automatic test_perf();
        perf_clr = 1;
        tick();
        perf_clr = 0;
        checks++; if (perf_stall_cnt !== 4'h0) begin errors++; $display("FAIL perf_clr0 got=%h exp=0", perf_stall_cnt); end
        stallreq_id = 1;
        for (int i = 0; i < 20; i++) tick();
        checks++; if (perf_stall_cnt !== 4'hF) begin errors++; $display("FAIL perf_sat got=%h exp=F", perf_stall_cnt); end
        perf_clr = 1;
        tick();
        perf_clr = 0; stallreq_id = 0;
        checks++; if (perf_stall_cnt !== 4'h0) begin errors++; $display("FAIL perf_clr_win got=%h exp=0", perf_stall_cnt); end
        exc_valid = 1;
        tick();
        exc_valid = 0;
        tick();
        checks++; if (perf_flush_cnt !== 4'h1) begin errors++; $display("FAIL perf_flush got=%h exp=1", perf_flush_cnt); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_id_stall();
        test_ex_stall();
        test_exception();
        test_eret_drain();
        test_exc_and_eret();
        test_reset_in_drain();
`ifdef PIPE_PERF_CNT_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
